bcd_timer_scan: RTL and testbench
=================================

Name: bcd_timer_scan

Overview:
Parametrised BCD seconds timer with an integrated 7-segment scan driver. It is the successor to the fixed 4-digit, 1 s up-counter. It adds configurable digit count and tick period, up/down counting, preset load, run/pause, wrap or stop-at-terminal mode, and multiplexed display outputs. It sits between the board clock and the 7-segment display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8)
CLK_DIV, 25_000_000, clk cycles (with clk_en high) per count tick
SCAN_DIV, 25_000, clk cycles per displayed digit during scan
WRAP, 1, 1 = wrap at terminal, 0 = hold at terminal
BLANK_LZ, 1, 1 = blank leading zeros on display (digit 0 is never blanked)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
clk_en  in  1  prescaler enable; prescaler frozen when low
run  in  1  1 = count on tick, 0 = pause (prescaler keeps running)
up_dn  in  1  1 = count up, 0 = count down
load  in  1  single-cycle preset strobe
load_val  in  4*NUM_DIGITS  preset value, BCD, digit 0 = LSBs
bcd_val  out  4*NUM_DIGITS  current count, BCD
tick  out  1  one-cycle pulse per prescaler period
term  out  1  one-cycle pulse when a tick hits the terminal value
seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
dig_sel  out  NUM_DIGITS  digit enable, one-hot, active-low

Behaviour:
- Reset (rst_n low at a clk edge): prescaler=0, bcd_val=0, tick=0, term=0, scan counter=0, digit index=0, seg=8'hFF, dig_sel=all 1s.
- Prescaler: increments only when clk_en=1. At CLK_DIV-1 with clk_en=1 it returns to 0 and tick is registered high for exactly one cycle.
- load=1: on the next edge bcd_val=load_val and prescaler=0. Any load_val digit >9 is clamped to 9. load has priority over a same-cycle tick; that tick is discarded and term stays 0.
- Count update happens on the edge after a cycle with tick=1, run=1 and load=0.
- Up count: BCD increment with ripple carry; a digit at 9 becomes 0 and carries.
- Down count: BCD decrement with ripple borrow; a digit at 0 becomes 9 and borrows.
- Terminal value is all-9 when counting up and all-0 when counting down.
- At terminal with a qualifying tick:
  - WRAP=1: value wraps (all-9 to 0, 0 to all-9).
  - WRAP=0: value holds.
  - In both modes term pulses high for one cycle, aligned with the update edge.
- A changed up_dn takes effect on the next tick; no intermediate state.
- run=0: bcd_val holds, term stays 0, tick still pulses.
- Scan:
  - The scan counter runs every cycle, independent of clk_en.
  - At SCAN_DIV-1 it returns to 0 and the digit index advances; the index wraps from NUM_DIGITS-1 to 0.
  - seg and dig_sel are registered one cycle after the index changes.
  - dig_sel bit[index] is 0 and all other bits are 1.
  - seg carries the standard hex-free decode for 0..9 with dp off (bit7=1).
  - With BLANK_LZ=1, a digit above the most significant nonzero digit drives seg=8'hFF. Digit 0 always displays.
- Arithmetic: the digit cascade is purely combinational within one cycle; no multi-cycle carry.

Decomposition:
- Package bcd_timer_pkg: 7-segment decode constants SEG_0..SEG_9 and SEG_BLANK (8'hFF), plus a function bcd_to_seg(digit).
- Sub-module bcd_digit: one BCD digit register.
  - Inputs: en, up_dn, load, load_digit, carry_in.
  - Outputs: digit, carry_out (9→0 on up, 0→9 on down).
  - Instantiated NUM_DIGITS times in a generate chain.
- Prescaler, scan counter, term detect and blanking logic live in the top module.

Test Plan:
1. NUM_DIGITS=4, CLK_DIV=4, run=1, up_dn=1, clk_en=1 from reset → tick every 4th cycle; bcd_val steps 0000,0001…0009,0010; 0099→0100; 0999→1000.
2. Load 16'h9998 with WRAP=1, up → 9999, then 0000 with term=1 for exactly one cycle. Repeat with WRAP=0 → holds at 9999, term pulses on each subsequent tick.
3. Load 16'h0100, up_dn=0 → 0099, 0098. Continue from 0001 → 0000, then 9999 with term pulse.
4. Assert load with load_val=16'h12AB in the same cycle as tick → bcd_val=1299, prescaler restarts at 0, term=0. Toggle run=0 for 10 ticks → bcd_val unchanged, tick still pulses. Hold clk_en=0 → no ticks.
5. Scan with SCAN_DIV=3, bcd_val=0042, BLANK_LZ=1 → dig_sel cycles 1110,1101,1011,0111 every 3 cycles; seg shows SEG_2, SEG_4, FF, FF.
6. Drive rst_n low mid-count and mid-scan for one edge → all outputs at reset values on that edge. Check no asynchronous response between edges.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared constants for the BCD timer: active-low 7-segment codes {dp,g,f,e,d,c,b,a}
// and the digit decode used by the scan driver.
package bcd_timer_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
      logic [7:0] s;
      case (digit)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer chain. carry_in from the previous digit requests a step;
// carry_out propagates when this digit rolls 9->0 (up) or 0->9 (down).
module bcd_digit
   import bcd_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up_dn,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       carry_in,
   output logic [3:0] digit,
   output logic       carry_out
);

   assign carry_out = carry_in & (up_dn ? (digit == BCD_MAX) : (digit == 4'd0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
      end else if (en && carry_in) begin
         if (up_dn)
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
         else
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_timer_scan.sv
// Parametrised BCD seconds timer (up/down, preset, wrap/hold) with a multiplexed
// active-low 7-segment scan driver.
module bcd_timer_scan
   import bcd_timer_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 25_000_000,
   parameter int SCAN_DIV   = 25_000,
   parameter int WRAP       = 1,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   input  logic                    run,
   input  logic                    up_dn,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   output logic [4*NUM_DIGITS-1:0] bcd_val,
   output logic                    tick,
   output logic                    term,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel
);

   localparam int PW = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
   localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0] pre_cnt;
   logic          pre_wrap;

   assign pre_wrap = (pre_cnt == PW'(CLK_DIV - 1));

   // A load restarts the prescaler, so it also swallows a wrap in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= clk_en & pre_wrap & ~load;
         if (load)
            pre_cnt <= '0;
         else if (clk_en)
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PW'(1);
      end
   end

   logic [NUM_DIGITS-1:0][3:0] digits;
   logic [NUM_DIGITS:0]        carry;
   logic                       count_en;
   logic                       at_term;
   logic                       step_en;

   // With carry_in tied high the chain's final carry is exactly the terminal detect.
   assign carry[0]  = 1'b1;
   assign at_term   = carry[NUM_DIGITS];
   assign count_en  = tick & run & ~load;
   assign step_en   = count_en & ((WRAP != 0) | ~at_term);

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (step_en),
         .up_dn      (up_dn),
         .load       (load),
         .load_digit (load_val[4*i +: 4]),
         .carry_in   (carry[i]),
         .digit      (digits[i]),
         .carry_out  (carry[i+1])
      );
   end

   assign bcd_val = digits;

   always_ff @(posedge clk) begin
      if (!rst_n)
         term <= 1'b0;
      else
         term <= count_en & at_term;
   end

   logic [NUM_DIGITS-1:0] blank;
   logic                  zero_above;

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above & (digits[i] == 4'd0);
         blank[i]   = (BLANK_LZ != 0) & zero_above;
      end
   end

   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg      <= SEG_BLANK;
         dig_sel  <= '1;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         seg     <= blank[idx] ? SEG_BLANK : bcd_to_seg(digits[idx]);
         dig_sel <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_bcd_timer_scan.sv
// Directed bench: a wrap DUT and a hold DUT share stimulus; a BCD reference model
// pushes expected results to a queue that is popped at each update edge.
module tb_bcd_timer_scan;
   import bcd_timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b1;
   logic        run = 1'b1;
   logic        up_dn = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0;

   logic [15:0] bcd_w, bcd_h;
   logic        tick_w, tick_h, term_w, term_h;
   logic [7:0]  seg_w, seg_h;
   logic [3:0]  sel_w, sel_h;

   always #5 clk = ~clk;

   bcd_timer_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .SCAN_DIV(3), .WRAP(1), .BLANK_LZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .run(run), .up_dn(up_dn), .load(load),
      .load_val(load_val), .bcd_val(bcd_w), .tick(tick_w), .term(term_w), .seg(seg_w),
      .dig_sel(sel_w));

   bcd_timer_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .SCAN_DIV(3), .WRAP(0), .BLANK_LZ(1)) dut_h (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .run(run), .up_dn(up_dn), .load(load),
      .load_val(load_val), .bcd_val(bcd_h), .tick(tick_h), .term(term_h), .seg(seg_h),
      .dig_sel(sel_h));

   typedef struct {
      logic [15:0] v_w;
      logic        t_w;
      logic [15:0] v_h;
      logic        t_h;
   } exp_t;

   typedef struct {
      logic [3:0] sel;
      logic [7:0] seg;
   } scan_t;

   exp_t        q[$];
   scan_t       sq[$];
   int          nvec = 0;
   int          nerr = 0;
   logic [15:0] ref_w = 16'h0;
   logic [15:0] ref_h = 16'h0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int b2i(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   function automatic logic [15:0] i2b(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [15:0] clamp(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++)
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      return r;
   endfunction

   function automatic logic [16:0] model_next(input logic [15:0] v, input logic up, input logic wrap);
      logic        t;
      logic [15:0] nv;
      if (up) begin
         t  = (v == 16'h9999);
         nv = t ? (wrap ? 16'h0000 : v) : i2b(b2i(v) + 1);
      end else begin
         t  = (v == 16'h0000);
         nv = t ? (wrap ? 16'h9999 : v) : i2b(b2i(v) - 1);
      end
      return {t, nv};
   endfunction

   task automatic pop_check(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = q.pop_front();
      chk({tag, "_val_w"}, {16'h0, bcd_w}, {16'h0, e.v_w});
      chk({tag, "_term_w"}, {31'h0, term_w}, {31'h0, e.t_w});
      chk({tag, "_val_h"}, {16'h0, bcd_h}, {16'h0, e.v_h});
      chk({tag, "_term_h"}, {31'h0, term_h}, {31'h0, e.t_h});
   endtask

   // Waits (bounded) for the next tick, predicts the update edge, then checks it.
   task automatic do_tick(input string tag);
      int   n = 0;
      exp_t e;
      logic [16:0] r;
      while (!tick_w && n < 16) begin
         step();
         n++;
      end
      if (!tick_w) begin
         chk({tag, "_tick_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (run && !load) begin
         r = model_next(ref_w, up_dn, 1'b1);
         ref_w = r[15:0];
         e.t_w = r[16];
         r = model_next(ref_h, up_dn, 1'b0);
         ref_h = r[15:0];
         e.t_h = r[16];
      end else begin
         e.t_w = 1'b0;
         e.t_h = 1'b0;
      end
      e.v_w = ref_w;
      e.v_h = ref_h;
      q.push_back(e);
      step();
      pop_check(tag);
   endtask

   task automatic do_load(input string tag, input logic [15:0] v);
      exp_t e;
      ref_w = clamp(v);
      ref_h = clamp(v);
      e = '{v_w: ref_w, t_w: 1'b0, v_h: ref_h, t_h: 1'b0};
      q.push_back(e);
      load = 1'b1;
      load_val = v;
      step();
      load = 1'b0;
      pop_check(tag);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_bcd"}, {16'h0, bcd_w}, 32'h0);
      chk({tag, "_bcd_h"}, {16'h0, bcd_h}, 32'h0);
      chk({tag, "_tick"}, {31'h0, tick_w}, 32'h0);
      chk({tag, "_term"}, {31'h0, term_w}, 32'h0);
      chk({tag, "_seg"}, {24'h0, seg_w}, 32'hFF);
      chk({tag, "_sel"}, {28'h0, sel_w}, 32'hF);
   endtask

   initial begin
      int n;
      logic [3:0] prev;
      scan_t s;

      // Reset state
      repeat (3) step();
      check_reset("reset");
      rst_n = 1'b1;

      // Up count from reset and decade carries
      for (int i = 1; i <= 10; i++) do_tick($sformatf("up%0d", i));
      do_load("ld_0098", 16'h0098);
      do_tick("up_0099");
      do_tick("up_0100");
      do_load("ld_0999", 16'h0999);
      do_tick("up_1000");

      // Terminal on the way up: wrap vs hold
      do_load("ld_9998", 16'h9998);
      do_tick("up_9999");
      do_tick("up_term");
      step();
      chk("term_once_w", {31'h0, term_w}, 32'h0);
      chk("term_once_h", {31'h0, term_h}, 32'h0);
      do_tick("after_term1");
      do_tick("after_term2");

      // Down count with borrows and terminal
      up_dn = 1'b0;
      do_load("ld_0100", 16'h0100);
      do_tick("dn_0099");
      do_tick("dn_0098");
      do_load("ld_0001", 16'h0001);
      do_tick("dn_0000");
      do_tick("dn_term");

      // Load colliding with a tick, then pause, then prescaler freeze
      up_dn = 1'b1;
      n = 0;
      while (!tick_w && n < 16) begin
         step();
         n++;
      end
      chk("pre_load_tick", {31'h0, tick_w}, 32'h1);
      do_load("ld_12AB_tick", 16'h12AB);
      n = 0;
      while (!tick_w && n < 16) begin
         step();
         n++;
      end
      chk("restart_latency", n, 32'd4);
      run = 1'b0;
      for (int i = 0; i < 10; i++) do_tick($sformatf("pause%0d", i));
      clk_en = 1'b0;
      run = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick_w) n++;
      end
      chk("clk_en_low_ticks", n, 32'd0);
      chk("clk_en_low_val", {16'h0, bcd_w}, {16'h0, ref_w});
      clk_en = 1'b1;

      // Scan with leading-zero blanking
      run = 1'b0;
      do_load("ld_0042", 16'h0042);
      n = 0;
      do begin
         prev = sel_w;
         step();
         n++;
      end while (!(sel_w == 4'b1110 && prev != 4'b1110) && n < 40);
      chk("scan_sync", {28'h0, sel_w}, 32'hE);
      for (int d = 0; d < 4; d++)
         for (int k = 0; k < 3; k++) begin
            s.sel = ~(4'b0001 << d);
            s.seg = (d == 0) ? SEG_2 : (d == 1) ? SEG_4 : SEG_BLANK;
            sq.push_back(s);
         end
      for (int i = 0; i < 12; i++) begin
         s = sq.pop_front();
         chk($sformatf("scan%0d_sel", i), {28'h0, sel_w}, {28'h0, s.sel});
         chk($sformatf("scan%0d_seg", i), {24'h0, seg_w}, {24'h0, s.seg});
         step();
      end

      // Synchronous reset mid-count / mid-scan
      repeat (2) step();
      rst_n = 1'b0;
      #2;
      chk("no_async_bcd", {16'h0, bcd_w}, 32'h0042);
      chk("no_async_sel", {31'h0, (sel_w != 4'hF)}, 32'h1);
      @(posedge clk);
      #1;
      check_reset("mid_reset");
      rst_n = 1'b1;
      step();
      chk("post_rst_sel", {28'h0, sel_w}, 32'hE);
      chk("post_rst_seg", {24'h0, seg_w}, {24'h0, SEG_0});
      n = 1;
      while (!tick_w && n < 16) begin
         step();
         n++;
      end
      chk("post_rst_tick", n, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
